// File: rtl/reset_release_sequencer_pkg.sv
// ============================================================================
// reset_seq_pkg : shared FSM state encoding and reset-cause codes
// Rev 1.0
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_t;

  localparam logic [1:0] CAUSE_EXT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_release_sequencer_sync_chain.sv
// ============================================================================
// reset_sync_chain : async-assert / sync-release reset synchronizer, active-high
// Rev 1.0
// ============================================================================
`default_nettype none

module reset_sync_chain #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  output logic sync_rst_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], 1'b0};
    end
  end

  assign sync_rst_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/reset_release_sequencer.sv
// ============================================================================
// reset_release_sequencer : synchronizes rst release, then frees NUM_OUTS
// resets in order; replays on software request. Option: ASYNC_RESET_SEQ_CAUSE_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module reset_release_sequencer
  import reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int NUM_OUTS       = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw_rst_req,
  output logic                sw_rst_ack,
  output logic [NUM_OUTS-1:0] rst_out,
  output logic                done
`ifdef ASYNC_RESET_SEQ_CAUSE_EN
  ,
  output logic [1:0]          rst_cause
`endif
);

  localparam int CNT_W = $clog2(max2(STRETCH_CYCLES, STAGE_GAP) + 1);
  localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  logic                sync_rst;
  logic                sw_accept;
  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_OUTS-1:0] rst_out_q, rst_out_d;
  logic                sw_seq_q, sw_seq_d;
  logic                ack_q, ack_d;

  reset_sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst        (rst),
    .sync_rst_o (sync_rst)
  );

  assign sw_accept = (state_q == RUN) && sw_rst_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      sw_seq_q  <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      sw_seq_q  <= sw_seq_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    sw_seq_d  = sw_seq_q;
    ack_d     = 1'b0;
    case (state_q)
      HOLD: begin
        if (!sync_rst) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
      end
      STRETCH: begin
        if (cnt_q == CNT_W'(STRETCH_CYCLES - 1)) begin
          cnt_d        = '0;
          rst_out_d[0] = 1'b0;
          idx_d        = IDX_W'(1);
          state_d      = (NUM_OUTS == 1) ? RUN : RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
          cnt_d     = '0;
          rst_out_d = rst_out_q & ~(NUM_OUTS'(1) << idx_q);
          if (idx_q == IDX_W'(NUM_OUTS - 1)) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (sw_seq_q) begin
          ack_d    = 1'b1;
          sw_seq_d = 1'b0;
        end
        // Software restart passes through HOLD (sync_rst already low) so the
        // release timing from the request edge is STRETCH_CYCLES+1+i*STAGE_GAP.
        if (sw_accept) begin
          rst_out_d = '1;
          cnt_d     = '0;
          sw_seq_d  = 1'b1;
          state_d   = HOLD;
        end
      end
      default: begin
        state_d   = HOLD;
        rst_out_d = '1;
      end
    endcase
  end

`ifdef ASYNC_RESET_SEQ_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause_q <= CAUSE_EXT;
    end else if (sw_accept) begin
      cause_q <= CAUSE_SW;
    end
  end

  assign rst_cause = cause_q;
`endif

  assign rst_out    = rst_out_q;
  assign done       = (state_q == RUN);
  assign sw_rst_ack = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_reset_release_sequencer.sv
// ============================================================================
// tb_reset_release_sequencer : scoreboard bench; stimulus queues timestamped
// output events, monitors pop them on every observed output change.
// ============================================================================
`default_nettype none

module tb_reset_release_sequencer;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       sw_req;
  logic [3:0] ro0;
  logic       done0, ack0;
  logic [0:0] ro1;
  logic       done1, ack1;
  logic [1:0] cause0, cause1;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q0[$];
  exp_t q1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_release_sequencer u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (sw_req),
    .sw_rst_ack (ack0),
    .rst_out    (ro0),
    .done       (done0)
`ifdef ASYNC_RESET_SEQ_CAUSE_EN
    ,
    .rst_cause  (cause0)
`endif
  );

  reset_release_sequencer #(
    .SYNC_STAGES    (2),
    .NUM_OUTS       (1),
    .STRETCH_CYCLES (1),
    .STAGE_GAP      (8)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .sw_rst_req (1'b0),
    .sw_rst_ack (ack1),
    .rst_out    (ro1),
    .done       (done1)
`ifdef ASYNC_RESET_SEQ_CAUSE_EN
    ,
    .rst_cause  (cause1)
`endif
  );

`ifndef ASYNC_RESET_SEQ_CAUSE_EN
  assign cause0 = 2'b00;
  assign cause1 = 2'b00;
`endif

  localparam logic [1:0] EXT = 2'b01;
  localparam logic [1:0] SW  = 2'b10;

  function automatic logic [7:0] mk(input logic [3:0] r, input logic d,
                                    input logic a, input logic [1:0] c);
`ifdef ASYNC_RESET_SEQ_CAUSE_EN
    return {r, d, a, c};
`else
    return {r, d, a, 2'b00};
`endif
  endfunction

  task automatic push0(input int c, input logic [3:0] r, input logic d,
                       input logic a, input logic [1:0] cs);
    exp_t e;
    e.cyc = c;
    e.v   = mk(r, d, a, cs);
    q0.push_back(e);
  endtask

  task automatic push1(input int c, input logic r, input logic d,
                       input logic [1:0] cs);
    exp_t e;
    e.cyc = c;
    e.v   = mk({3'b000, r}, d, 1'b0, cs);
    q1.push_back(e);
  endtask

  task automatic wait_cyc(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_sw(input int e);
    wait_cyc(e - 1);
    sw_req = 1'b1;
    wait_cyc(e);
    sw_req = 1'b0;
  endtask

  // Asserts rst mid-cycle after edge e and releases it after edge e+1.
  task automatic rst_pulse(input int e);
    wait_cyc(e);
    @(negedge clk);
    #2;
    rst = 1'b1;
    wait_cyc(e + 1);
    rst = 1'b0;
  endtask

  initial begin : mon0
    logic [7:0] prev, cur;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      cur = {ro0, done0, ack0, cause0};
      if (cur !== prev) begin
        prev = cur;
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL dut0_event: unexpected change to %h at cyc %0d", cur, cyc);
        end else begin
          e = q0.pop_front();
          if (e.cyc != cyc || cur !== e.v) begin
            n_err++;
            $display("FAIL dut0_event: got %h at cyc %0d, required %h at cyc %0d",
                     cur, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  initial begin : mon1
    logic [7:0] prev, cur;
    exp_t e;
    prev = 'x;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      cur = {3'b000, ro1, done1, ack1, cause1};
      if (cur !== prev) begin
        prev = cur;
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL dut1_event: unexpected change to %h at cyc %0d", cur, cyc);
        end else begin
          e = q1.pop_front();
          if (e.cyc != cyc || cur !== e.v) begin
            n_err++;
            $display("FAIL dut1_event: got %h at cyc %0d, required %h at cyc %0d",
                     cur, cyc, e.v, e.cyc);
          end
        end
      end
    end
  end

  initial begin : stim
    rst    = 1'b0;
    sw_req = 1'b0;

    // Power-on reset: asserted before any clock edge, released after edge 3.
    push0(0, 4'hF, 1'b0, 1'b0, EXT);
    push1(0, 1'b1, 1'b0, EXT);
    #2 rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    push1(7, 1'b0, 1'b1, EXT);
    push0(23, 4'hE, 1'b0, 1'b0, EXT);
    push0(31, 4'hC, 1'b0, 1'b0, EXT);
    push0(39, 4'h8, 1'b0, 1'b0, EXT);
    push0(47, 4'h0, 1'b1, 1'b0, EXT);
    // Requests during STRETCH and RELEASE must be ignored.
    pulse_sw(13);
    pulse_sw(33);

    // Software sequence accepted at edge 55.
    push0(55, 4'hF, 1'b0, 1'b0, SW);
    push0(72, 4'hE, 1'b0, 1'b0, SW);
    push0(80, 4'hC, 1'b0, 1'b0, SW);
    push0(88, 4'h8, 1'b0, 1'b0, SW);
    push0(96, 4'h0, 1'b1, 1'b0, SW);
    push0(97, 4'h0, 1'b1, 1'b1, SW);
    push0(98, 4'h0, 1'b1, 1'b0, SW);
    pulse_sw(55);

    // New external reset, then an abort while rst_out=C.
    push0(100, 4'hF, 1'b0, 1'b0, EXT);
    push1(100, 1'b1, 1'b0, EXT);
    push1(105, 1'b0, 1'b1, EXT);
    push0(121, 4'hE, 1'b0, 1'b0, EXT);
    push0(129, 4'hC, 1'b0, 1'b0, EXT);
    rst_pulse(100);
    push0(131, 4'hF, 1'b0, 1'b0, EXT);
    push1(131, 1'b1, 1'b0, EXT);
    push1(136, 1'b0, 1'b1, EXT);
    push0(152, 4'hE, 1'b0, 1'b0, EXT);
    push0(160, 4'hC, 1'b0, 1'b0, EXT);
    push0(168, 4'h8, 1'b0, 1'b0, EXT);
    push0(176, 4'h0, 1'b1, 1'b0, EXT);
    rst_pulse(131);

    // Software sequence aborted by rst: no ack afterwards.
    push0(180, 4'hF, 1'b0, 1'b0, SW);
    push0(197, 4'hE, 1'b0, 1'b0, SW);
    pulse_sw(180);
    push0(200, 4'hF, 1'b0, 1'b0, EXT);
    push1(200, 1'b1, 1'b0, EXT);
    push1(205, 1'b0, 1'b1, EXT);
    push0(221, 4'hE, 1'b0, 1'b0, EXT);
    push0(229, 4'hC, 1'b0, 1'b0, EXT);
    push0(237, 4'h8, 1'b0, 1'b0, EXT);
    push0(245, 4'h0, 1'b1, 1'b0, EXT);
    rst_pulse(200);

    wait_cyc(260);
    while (q0.size() != 0) begin
      exp_t e;
      e = q0.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL dut0_missing: got no event, required %h at cyc %0d", e.v, e.cyc);
    end
    while (q1.size() != 0) begin
      exp_t e;
      e = q1.pop_front();
      n_cmp++;
      n_err++;
      $display("FAIL dut1_missing: got no event, required %h at cyc %0d", e.v, e.cyc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
